// File: rtl/helper_ctrl_arbiter_pkg.sv
// Shared definitions for the helper control path: control-byte bit
// positions (also used by the LoRa receiver) and the arbiter state codes.
package helper_ctrl_arbiter_pkg;

    localparam int LED_BIT  = 7;
    localparam int RGB_BIT  = 6;
    localparam int BELL_BIT = 5;
    localparam int MODE_MSB = 4;
    localparam int MODE_LSB = 2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REMOTE   = 2'd1;
    localparam logic [1:0] ST_LOCAL    = 2'd2;
    localparam logic [1:0] ST_FAILSAFE = 2'd3;

endpackage

// File: rtl/bell_sequencer.sv
// Bell sequencer: turns a steady enable into an audible on/off pattern
// measured in millisecond ticks, starting with an on-phase.
module bell_sequencer #(
    parameter int BELL_ON_MS  = 200,
    parameter int BELL_OFF_MS = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic en,
    output logic bell
);

    localparam int MAXP = (BELL_ON_MS > BELL_OFF_MS) ? BELL_ON_MS : BELL_OFF_MS;
    localparam int PW   = $clog2(MAXP + 1);

    logic [PW-1:0] phase_q, phase_d;
    logic          bell_q, bell_d;

    // A zero phase counter while enabled means the enable has just risen,
    // because an enabled sequencer always holds a nonzero phase length.
    always_comb begin
        phase_d = phase_q;
        bell_d  = bell_q;
        if (!en) begin
            phase_d = '0;
            bell_d  = 1'b0;
        end else if (phase_q == '0) begin
            phase_d = PW'(BELL_ON_MS);
            bell_d  = 1'b1;
        end else if (tick) begin
            if (phase_q == PW'(1)) begin
                bell_d  = !bell_q;
                phase_d = bell_q ? PW'(BELL_OFF_MS) : PW'(BELL_ON_MS);
            end else begin
                phase_d = phase_q - PW'(1);
            end
        end
    end

    // Phase and bell state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            bell_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            bell_q  <= bell_d;
        end
    end

    assign bell = bell_q;

endmodule

// File: rtl/helper_ctrl_arbiter.sv
// Output owner for the helper: arbitrates lamps and bell between the LoRa
// link and the local panel, supervises the link with a ms watchdog and
// falls back to a safe control byte when the link is lost.
module helper_ctrl_arbiter
    import helper_ctrl_arbiter_pkg::*;
#(
    parameter int         TICK_DIV        = 50000,
    parameter int         LINK_TIMEOUT_MS = 2000,
    parameter int         HOLD_MS         = 5000,
    parameter int         BELL_ON_MS      = 200,
    parameter int         BELL_OFF_MS     = 300,
    parameter logic [7:0] FAILSAFE_CTRL   = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lora_ok,
    input  logic [7:0] lora_ctrl,
    input  logic       local_req,
    input  logic [7:0] local_ctrl,
    output logic       led,
    output logic       rgb,
    output logic [2:0] rgb_mode,
    output logic       bell,
    output logic       src_remote,
    output logic       link_up
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = $clog2(LINK_TIMEOUT_MS + 1);
    localparam int HW = $clog2(HOLD_MS + 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic [WW-1:0] wd_q, wd_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    state_q, state_d;
    logic [7:2]    shadow_q, shadow_d;
    logic [7:2]    localCtrl_q, localCtrl_d;
    logic [7:2]    activeCtrl_q, activeCtrl_d;
    logic          linkUp_q, linkUp_d;
    logic          wdExpire, holdExpire;
    logic          unusedReserved;

    assign unusedReserved = ^{lora_ctrl[1:0], local_ctrl[1:0]};

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    // Free-running millisecond prescaler; the tick fires on the wrap cycle.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Watchdog, hold timer and the two latched control bytes. Frames always
    // refresh the shadow and watchdog, whichever source owns the outputs.
    always_comb begin
        wd_d = wd_q;
        if (lora_ok) begin
            wd_d = WW'(LINK_TIMEOUT_MS);
        end else if (tick && (wd_q != '0)) begin
            wd_d = wd_q - WW'(1);
        end
        hold_d = hold_q;
        if (local_req) begin
            hold_d = HW'(HOLD_MS);
        end else if (tick && (hold_q != '0)) begin
            hold_d = hold_q - HW'(1);
        end
        shadow_d    = lora_ok ? lora_ctrl[7:2] : shadow_q;
        localCtrl_d = local_req ? local_ctrl[7:2] : localCtrl_q;
    end

    assign wdExpire   = !lora_ok && tick && (wd_q == WW'(1));
    assign holdExpire = !local_req && tick && (hold_q == HW'(1));
    assign linkUp_d   = (wd_d != '0);

    // Ownership FSM. Local requests always win; a lapsing hold returns to the
    // radio only if the watchdog is still alive after this cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FAILSAFE: begin
                if (local_req) begin
                    state_d = ST_LOCAL;
                end else if (lora_ok) begin
                    state_d = ST_REMOTE;
                end
            end
            ST_REMOTE: begin
                if (local_req) begin
                    state_d = ST_LOCAL;
                end else if (wdExpire) begin
                    state_d = ST_FAILSAFE;
                end
            end
            ST_LOCAL: begin
                if (holdExpire) begin
                    state_d = linkUp_d ? ST_REMOTE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The active byte follows the next state so a strobe shows one cycle later.
    always_comb begin
        case (state_d)
            ST_REMOTE:   activeCtrl_d = shadow_d;
            ST_LOCAL:    activeCtrl_d = localCtrl_d;
            ST_FAILSAFE: activeCtrl_d = FAILSAFE_CTRL[7:2];
            default:     activeCtrl_d = '0;
        endcase
    end

    // All arbiter state, cleared asynchronously so nothing survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            wd_q         <= '0;
            hold_q       <= '0;
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            localCtrl_q  <= '0;
            activeCtrl_q <= '0;
            linkUp_q     <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            wd_q         <= wd_d;
            hold_q       <= hold_d;
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            localCtrl_q  <= localCtrl_d;
            activeCtrl_q <= activeCtrl_d;
            linkUp_q     <= linkUp_d;
        end
    end

    bell_sequencer #(
        .BELL_ON_MS  (BELL_ON_MS),
        .BELL_OFF_MS (BELL_OFF_MS)
    ) u_bell (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .en   (activeCtrl_q[BELL_BIT]),
        .bell (bell)
    );

    assign led        = activeCtrl_q[LED_BIT];
    assign rgb        = activeCtrl_q[RGB_BIT];
    assign rgb_mode   = activeCtrl_q[MODE_MSB:MODE_LSB];
    assign src_remote = (state_q == ST_REMOTE);
    assign link_up    = linkUp_q;

endmodule

// File: tb/tb_helper_ctrl_arbiter.sv
// Bench for helper_ctrl_arbiter: fixed vectors, hand-written corner
// sequences and random strobes, all compared against a timestamp-based
// reference model of ownership, link and bell timing.
module tb_helper_ctrl_arbiter;

    localparam int TICK = 4;
    localparam int LINK = 5;
    localparam int HOLD = 8;
    localparam int BON  = 2;
    localparam int BOFF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lora_ok = 1'b0;
    logic [7:0] lora_ctrl = 8'h00;
    logic       local_req = 1'b0;
    logic [7:0] local_ctrl = 8'h00;
    logic       led, rgb, bell, src_remote, link_up;
    logic [2:0] rgb_mode;

    always #5 clk = ~clk;

    helper_ctrl_arbiter #(
        .TICK_DIV        (TICK),
        .LINK_TIMEOUT_MS (LINK),
        .HOLD_MS         (HOLD),
        .BELL_ON_MS      (BON),
        .BELL_OFF_MS     (BOFF),
        .FAILSAFE_CTRL   (8'h80)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lora_ok    (lora_ok),
        .lora_ctrl  (lora_ctrl),
        .local_req  (local_req),
        .local_ctrl (local_ctrl),
        .led        (led),
        .rgb        (rgb),
        .rgb_mode   (rgb_mode),
        .bell       (bell),
        .src_remote (src_remote),
        .link_up    (link_up)
    );

    int checks = 0;
    int errors = 0;

    typedef enum {OWN_NONE, OWN_RADIO, OWN_PANEL, OWN_SAFE} owner_e;

    owner_e     mOwner;
    int         mCyc;
    bit         mHaveLora, mHaveLocal;
    int         mLoraCyc, mLocalCyc, mRise;
    logic [7:0] mShadow, mLocalByte, mActive;
    bit         mEnLast, mBell, mLink;

    typedef struct {
        bit         lo;
        logic [7:0] lc;
        bit         lr;
        logic [7:0] lcc;
        bit         eLed;
        bit         eRgb;
        logic [2:0] eMode;
        bit         eSrc;
        bit         eLink;
    } vec_t;

    vec_t vecs[6];

    // Ticks that have occurred in cycles 0..k since reset release.
    function automatic int ticksThru(int k);
        return (k + 1) / TICK;
    endfunction

    // True if a timer loaded at the end of cycle start is nonzero in cycle k.
    function automatic bit runningIn(bit have, int start, int len, int k);
        return have && (start < k) && ((ticksThru(k - 1) - ticksThru(start)) < len);
    endfunction

    task automatic check1(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        mOwner = OWN_NONE;
        mCyc = 0;
        mHaveLora = 1'b0;
        mHaveLocal = 1'b0;
        mLoraCyc = 0;
        mLocalCyc = 0;
        mRise = 0;
        mShadow = 8'h00;
        mLocalByte = 8'h00;
        mActive = 8'h00;
        mEnLast = 1'b0;
        mBell = 1'b0;
        mLink = 1'b0;
    endtask

    // Advance the model by the cycle whose inputs are given.
    task automatic modelStep(bit lo, logic [7:0] lc, bit lr, logic [7:0] lcc);
        int c;
        bit wdExp, holdExp, enC, linkNext;
        int n;
        c = mCyc;
        wdExp = !lo && runningIn(mHaveLora, mLoraCyc, LINK, c)
                    && !runningIn(mHaveLora, mLoraCyc, LINK, c + 1);
        holdExp = !lr && runningIn(mHaveLocal, mLocalCyc, HOLD, c)
                      && !runningIn(mHaveLocal, mLocalCyc, HOLD, c + 1);
        if (lo) begin
            mShadow = lc;
            mHaveLora = 1'b1;
            mLoraCyc = c;
        end
        if (lr) begin
            mLocalByte = lcc;
            mHaveLocal = 1'b1;
            mLocalCyc = c;
        end
        linkNext = runningIn(mHaveLora, mLoraCyc, LINK, c + 1);
        case (mOwner)
            OWN_NONE, OWN_SAFE: begin
                if (lr) mOwner = OWN_PANEL;
                else if (lo) mOwner = OWN_RADIO;
            end
            OWN_RADIO: begin
                if (lr) mOwner = OWN_PANEL;
                else if (wdExp) mOwner = OWN_SAFE;
            end
            default: begin
                if (!lr && holdExp) mOwner = linkNext ? OWN_RADIO : OWN_NONE;
            end
        endcase
        enC = mActive[5];
        if (!enC) begin
            mBell = 1'b0;
        end else begin
            if (!mEnLast) mRise = c + 1;
            n = ticksThru(c) - ticksThru(mRise - 1);
            mBell = (n % (BON + BOFF)) < BON;
        end
        mEnLast = enC;
        case (mOwner)
            OWN_RADIO: mActive = mShadow;
            OWN_PANEL: mActive = mLocalByte;
            OWN_SAFE:  mActive = 8'h80;
            default:   mActive = 8'h00;
        endcase
        mLink = linkNext;
        mCyc = c + 1;
    endtask

    task automatic checkOutput();
        check1("led", int'(led), int'(mActive[7]));
        check1("rgb", int'(rgb), int'(mActive[6]));
        check1("rgb_mode", int'(rgb_mode), int'(mActive[4:2]));
        check1("bell", int'(bell), int'(mBell));
        check1("src_remote", int'(src_remote), int'(mOwner == OWN_RADIO));
        check1("link_up", int'(link_up), int'(mLink));
    endtask

    // One clock cycle of stimulus; ends on a falling edge.
    task automatic applyStimulus(bit lo, logic [7:0] lc, bit lr, logic [7:0] lcc);
        lora_ok = lo;
        lora_ctrl = lc;
        local_req = lr;
        local_ctrl = lcc;
        @(posedge clk);
        #1;
        modelStep(lo, lc, lr, lcc);
        lora_ok = 1'b0;
        local_req = 1'b0;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock.
    task automatic doReset();
        lora_ok = 1'b0;
        local_req = 1'b0;
        rst = 1'b1;
        #1;
        modelReset();
        check1("reset_led", int'(led), 0);
        check1("reset_rgb", int'(rgb), 0);
        check1("reset_mode", int'(rgb_mode), 0);
        check1("reset_bell", int'(bell), 0);
        check1("reset_src", int'(src_remote), 0);
        check1("reset_link", int'(link_up), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int p, h1, l1, h2;
        bit rec[48];

        vecs[0] = '{1'b1, 8'hC8, 1'b0, 8'h00, 1'b1, 1'b1, 3'b010, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 3'b010, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'hC0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h48, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h84, 1'b1, 8'h1C, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1};

        // Fixed vectors from reset.
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].lo, vecs[i].lc, vecs[i].lr, vecs[i].lcc);
            check1($sformatf("vec%0d_led", i), int'(led), int'(vecs[i].eLed));
            check1($sformatf("vec%0d_rgb", i), int'(rgb), int'(vecs[i].eRgb));
            check1($sformatf("vec%0d_mode", i), int'(rgb_mode), int'(vecs[i].eMode));
            check1($sformatf("vec%0d_src", i), int'(src_remote), int'(vecs[i].eSrc));
            check1($sformatf("vec%0d_link", i), int'(link_up), int'(vecs[i].eLink));
        end

        // Link loss into failsafe, then recovery by a new frame.
        doReset();
        applyStimulus(1'b1, 8'h80, 1'b0, 8'h00);
        n = 1;
        for (int i = 0; i < 30; i++) begin
            idle();
            n++;
            if (!link_up) break;
        end
        check1("failsafe_within_20", int'(n <= 20), 1);
        check1("failsafe_led", int'(led), 1);
        check1("failsafe_rgb", int'(rgb), 0);
        check1("failsafe_src", int'(src_remote), 0);
        applyStimulus(1'b1, 8'h40, 1'b0, 8'h00);
        check1("recover_led", int'(led), 0);
        check1("recover_rgb", int'(rgb), 1);
        check1("recover_src", int'(src_remote), 1);

        // Local override of a live link, hand-back after the hold.
        doReset();
        applyStimulus(1'b1, 8'h80, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h04);
        check1("override_led", int'(led), 0);
        check1("override_mode", int'(rgb_mode), 1);
        check1("override_src", int'(src_remote), 0);
        applyStimulus(1'b1, 8'hC0, 1'b0, 8'h00);
        check1("hold_ignores_led", int'(led), 0);
        check1("hold_ignores_rgb", int'(rgb), 0);
        n = 2;
        for (int j = 1; j <= 40; j++) begin
            applyStimulus((j % 8) == 0, 8'hC0, 1'b0, 8'h00);
            n++;
            if (src_remote) break;
        end
        check1("handback_within_32", int'(n <= 32), 1);
        check1("handback_led", int'(led), 1);
        check1("handback_rgb", int'(rgb), 1);
        check1("handback_link", int'(link_up), 1);

        // Simultaneous strobes, then hold outlasting the watchdog.
        doReset();
        applyStimulus(1'b1, 8'hC0, 1'b1, 8'h04);
        check1("simul_led", int'(led), 0);
        check1("simul_mode", int'(rgb_mode), 1);
        check1("simul_src", int'(src_remote), 0);
        check1("simul_link", int'(link_up), 1);
        n = 1;
        for (int j = 0; j < 45; j++) begin
            idle();
            n++;
            if (rgb_mode == 3'b000) break;
        end
        check1("lapse_within_32", int'(n <= 32), 1);
        check1("lapse_led", int'(led), 0);
        check1("lapse_rgb", int'(rgb), 0);
        check1("lapse_src", int'(src_remote), 0);
        check1("lapse_link", int'(link_up), 0);
        check1("lapse_bell", int'(bell), 0);

        // Bell pattern: 2 ticks on, 3 ticks off, repeating.
        doReset();
        applyStimulus(1'b1, 8'h20, 1'b0, 8'h00);
        for (int j = 0; j < 48; j++) begin
            applyStimulus((j % 8) == 7, 8'h20, 1'b0, 8'h00);
            rec[j] = bell;
        end
        p = 0;
        while (p < 48 && !rec[p]) p++;
        h1 = 0;
        while (p < 48 && rec[p]) begin h1++; p++; end
        l1 = 0;
        while (p < 48 && !rec[p]) begin l1++; p++; end
        h2 = 0;
        while (p < 48 && rec[p]) begin h2++; p++; end
        check1("bell_first_on_range", int'(h1 >= (BON - 1) * TICK + 1 && h1 <= BON * TICK), 1);
        check1("bell_off_len", l1, BOFF * TICK);
        check1("bell_second_on_len", h2, BON * TICK);
        applyStimulus(1'b1, 8'h00, 1'b0, 8'h00);
        idle();
        check1("bell_clear", int'(bell), 0);

        // Reset in the middle of a local hold with the bell ringing.
        doReset();
        applyStimulus(1'b1, 8'h80, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hA0);
        for (int j = 0; j < 4; j++) idle();
        check1("prereset_bell", int'(bell), 1);
        check1("prereset_led", int'(led), 1);
        doReset();
        for (int j = 0; j < 12; j++) idle();
        check1("postreset_quiet_link", int'(link_up), 0);
        check1("postreset_quiet_led", int'(led), 0);

        // Random strobes against the model.
        doReset();
        for (int j = 0; j < 3000; j++) begin
            applyStimulus($urandom_range(0, 9) == 0, 8'($urandom),
                          $urandom_range(0, 39) == 0, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
